univ_shift_reg: RTL and testbench

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/univ_shift_reg_pkg.sv | 26 ++
 rtl/univ_shift_reg_shift_core.sv | 43 ++++
 rtl/univ_shift_reg.sv | 127 ++++++++++++
 tb/tb_univ_shift_reg.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/univ_shift_reg_pkg.sv
// Shared encodings for the universal shift register: operation modes and controller states.
package univ_shift_reg_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_ROR  = 3'b101,
        MODE_ASR  = 3'b110,
        MODE_CLR  = 3'b111
    } usr_mode_e;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } usr_state_e;

    // Modes that move a bit out of the register and therefore update sout.
    function automatic logic is_shift_mode(input usr_mode_e m);
        return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) ||
               (m == MODE_ROR) || (m == MODE_ASR);
    endfunction

endpackage

// File: rtl/univ_shift_reg_shift_core.sv
// Single-step shift/rotate next-value logic; hold, load and clear modes pass q through unchanged.
module usr_shift_core
    import univ_shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q_i,
    input  usr_mode_e        mode_i,
    input  logic             sin_i,
    output logic [WIDTH-1:0] q_next_o,
    output logic             out_bit_o
);

    always_comb begin
        q_next_o  = q_i;
        out_bit_o = 1'b0;
        case (mode_i)
            MODE_SHL: begin
                q_next_o  = {q_i[WIDTH-2:0], sin_i};
                out_bit_o = q_i[WIDTH-1];
            end
            MODE_SHR: begin
                q_next_o  = {sin_i, q_i[WIDTH-1:1]};
                out_bit_o = q_i[0];
            end
            MODE_ROL: begin
                q_next_o  = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
                out_bit_o = q_i[WIDTH-1];
            end
            MODE_ROR: begin
                q_next_o  = {q_i[0], q_i[WIDTH-1:1]};
                out_bit_o = q_i[0];
            end
            MODE_ASR: begin
                q_next_o  = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
                out_bit_o = q_i[0];
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with single-cycle mode operations and a zero-filling multi-cycle burst shift.
//   state | meaning
//   IDLE  | accepts start (burst) or en/mode (single-cycle op)
//   BURST | one logical shift per cycle until the latched count is used up; inputs ignored
module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(8'hAA),
    parameter int               AMT_W     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    input  logic             start,
    input  logic             dir,
    input  logic [AMT_W-1:0] amt,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    usr_state_e       state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             sout_q, sout_d;
    logic             done_q, done_d;
    logic             dir_q, dir_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;

    usr_mode_e        core_mode;
    logic             core_sin;
    logic [WIDTH-1:0] core_q;
    logic             core_out;

    // Bursts reuse the same core as a plain logical shift with a zero fill.
    always_comb begin
        if (state_q == BURST) begin
            core_mode = dir_q ? MODE_SHR : MODE_SHL;
            core_sin  = 1'b0;
        end else begin
            core_mode = usr_mode_e'(mode);
            core_sin  = sin;
        end
    end

    usr_shift_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .q_i       (q_q),
        .mode_i    (core_mode),
        .sin_i     (core_sin),
        .q_next_o  (core_q),
        .out_bit_o (core_out)
    );

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        sout_d  = sout_q;
        done_d  = 1'b0;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = BURST;
                    cnt_d   = amt;
                    dir_d   = dir;
                end else if (en) begin
                    if (usr_mode_e'(mode) == MODE_LOAD) begin
                        q_d = d;
                    end else if (usr_mode_e'(mode) == MODE_CLR) begin
                        q_d = '0;
                    end else if (is_shift_mode(usr_mode_e'(mode))) begin
                        q_d    = core_q;
                        sout_d = core_out;
                    end
                end
            end
            BURST: begin
                // A zero count still spends one cycle here, just without shifting.
                if (cnt_q != '0) begin
                    q_d    = core_q;
                    sout_d = core_out;
                    cnt_d  = cnt_q - AMT_W'(1);
                end
                if (cnt_q <= AMT_W'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            q_q     <= RESET_VAL;
            sout_q  <= 1'b0;
            done_q  <= 1'b0;
            dir_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            sout_q  <= sout_d;
            done_q  <= done_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
        end
    end

    assign q    = q_q;
    assign sout = sout_q;
    assign zero = (q_q == '0);
    assign busy = (state_q == BURST);
    assign done = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Randomized and directed bench for univ_shift_reg against a cycle-count behavioural model.
module tb_univ_shift_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, en, sin, start, dir;
    logic [2:0] mode, amt;
    logic [7:0] d;
    logic [7:0] q;
    logic       sout, zero, busy, done;

    logic        rst16_n, en16, sin16, start16, dir16;
    logic [2:0]  mode16;
    logic [4:0]  amt16;
    logic [15:0] d16;
    logic [15:0] q16;
    logic        sout16, zero16, busy16, done16;

    univ_shift_reg dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .mode  (mode),
        .d     (d),
        .sin   (sin),
        .start (start),
        .dir   (dir),
        .amt   (amt),
        .q     (q),
        .sout  (sout),
        .zero  (zero),
        .busy  (busy),
        .done  (done)
    );

    univ_shift_reg #(
        .WIDTH (16),
        .AMT_W (5)
    ) dut16 (
        .clk   (clk),
        .rst_n (rst16_n),
        .en    (en16),
        .mode  (mode16),
        .d     (d16),
        .sin   (sin16),
        .start (start16),
        .dir   (dir16),
        .amt   (amt16),
        .q     (q16),
        .sout  (sout16),
        .zero  (zero16),
        .busy  (busy16),
        .done  (done16)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: a burst is "busy for max(amt,1) cycles, shifting amt of them".
    logic [7:0] m_q = 8'hAA;
    logic       m_sout = 1'b0;
    logic       m_done = 1'b0;
    logic       m_dir = 1'b0;
    int         m_busy_left = 0;
    int         m_shifts_left = 0;

    task automatic model_edge();
        if (!rst_n) begin
            m_q = 8'hAA; m_sout = 1'b0; m_done = 1'b0;
            m_busy_left = 0; m_shifts_left = 0;
        end else if (m_busy_left > 0) begin
            if (m_shifts_left > 0) begin
                if (m_dir) begin m_sout = m_q[0]; m_q = m_q >> 1; end
                else       begin m_sout = m_q[7]; m_q = m_q << 1; end
                m_shifts_left--;
            end
            m_busy_left--;
            m_done = (m_busy_left == 0);
        end else begin
            m_done = 1'b0;
            if (start) begin
                m_shifts_left = int'(amt);
                m_busy_left   = (amt == 0) ? 1 : int'(amt);
                m_dir         = dir;
            end else if (en) begin
                case (mode)
                    3'd1: m_q = d;
                    3'd2: begin m_sout = m_q[7]; m_q = (m_q << 1) | {7'd0, sin}; end
                    3'd3: begin m_sout = m_q[0]; m_q = (m_q >> 1) | {sin, 7'd0}; end
                    3'd4: begin m_sout = m_q[7]; m_q = (m_q << 1) | (m_q >> 7); end
                    3'd5: begin m_sout = m_q[0]; m_q = (m_q >> 1) | (m_q << 7); end
                    3'd6: begin m_sout = m_q[0]; m_q = $unsigned($signed(m_q) >>> 1); end
                    3'd7: m_q = 8'd0;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("q", q, m_q);
        chk("sout", sout, m_sout);
        chk("busy", busy, m_busy_left > 0);
        chk("done", done, m_done);
        chk("zero", zero, m_q == 8'd0);
    endtask

    task automatic run_burst(output int n);
        n = 0;
        for (int g = 0; g < 64 && busy; g++) begin
            n++;
            tick();
        end
        chk("burst_bound", busy, 1'b0);
    endtask

    task automatic tick16();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        rst_n = 1'b0; en = 1'b0; mode = 3'd0; d = 8'd0; sin = 1'b0;
        start = 1'b0; dir = 1'b0; amt = 3'd0;
        rst16_n = 1'b0; en16 = 1'b0; mode16 = 3'd0; d16 = 16'd0; sin16 = 1'b0;
        start16 = 1'b0; dir16 = 1'b0; amt16 = 5'd0;

        tick(); tick();
        chk("rst_q", q, 8'hAA);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_zero", zero, 1'b0);
        rst_n = 1'b1;

        en = 1'b1; mode = 3'd1; d = 8'hAA; tick();
        mode = 3'd2; sin = 1'b1; tick();
        chk("shl_q", q, 8'h55); chk("shl_sout", sout, 1'b1);
        mode = 3'd5; sin = 1'b0; tick();
        chk("ror_q", q, 8'hAA); chk("ror_sout", sout, 1'b1);
        mode = 3'd6; tick();
        chk("asr_q", q, 8'hD5); chk("asr_sout", sout, 1'b0);

        mode = 3'd1; d = 8'h81; tick();
        en = 1'b0;
        start = 1'b1; dir = 1'b0; amt = 3'd3; tick();
        start = 1'b0;
        run_burst(nb);
        chk("burst3_cycles", nb, 3);
        chk("burst3_q", q, 8'h08);
        chk("burst3_done", done, 1'b1);
        start = 1'b1; dir = 1'b1; amt = 3'd0; tick();
        start = 1'b0;
        chk("burst0_busy", busy, 1'b1);
        run_burst(nb);
        chk("burst0_cycles", nb, 1);
        chk("burst0_q", q, 8'h08);
        chk("burst0_done", done, 1'b1);
        tick();
        chk("done_pulse", done, 1'b0);

        en = 1'b1; mode = 3'd1; d = 8'hF0; tick();
        en = 1'b0; start = 1'b1; dir = 1'b1; amt = 3'd2; tick();
        en = 1'b1; mode = 3'd7; start = 1'b1; dir = 1'b0; amt = 3'd7;
        run_burst(nb);
        en = 1'b0; start = 1'b0;
        chk("lock_cycles", nb, 2);
        chk("lock_q", q, 8'h3C);
        chk("lock_done", done, 1'b1);
        tick();

        en = 1'b1; mode = 3'd1; d = 8'h81; tick();
        en = 1'b0; start = 1'b1; dir = 1'b0; amt = 3'd5; tick();
        start = 1'b0; tick();
        rst_n = 1'b0; tick();
        chk("midrst_q", q, 8'hAA);
        chk("midrst_busy", busy, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("midrst_nodone", done, 1'b0);
        end

        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 79) != 0);
            en    = $urandom_range(0, 1);
            mode  = 3'($urandom_range(0, 7));
            d     = 8'($urandom);
            sin   = $urandom_range(0, 1);
            start = ($urandom_range(0, 7) == 0);
            dir   = $urandom_range(0, 1);
            amt   = 3'($urandom_range(0, 7));
            tick();
        end
        rst_n = 1'b1; start = 1'b0; en = 1'b0;

        tick16(); tick16();
        chk("w16_rst_q", q16, 16'h00AA);
        rst16_n = 1'b1;
        en16 = 1'b1; mode16 = 3'd1; d16 = 16'h8000; tick16();
        en16 = 1'b0;
        chk("w16_load_q", q16, 16'h8000);
        chk("w16_load_zero", zero16, 1'b0);
        start16 = 1'b1; dir16 = 1'b1; amt16 = 5'd20; tick16();
        start16 = 1'b0;
        nb = 0;
        for (int g = 0; g < 64 && busy16; g++) begin
            nb++;
            tick16();
        end
        chk("w16_bound", busy16, 1'b0);
        chk("w16_cycles", nb, 20);
        chk("w16_q", q16, 16'h0000);
        chk("w16_zero", zero16, 1'b1);
        chk("w16_done", done16, 1'b1);
        tick16();
        chk("w16_done_pulse", done16, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
